prog_chain_loader: RTL

//  Configuration controller for the serial program chain of an io_bank (chained io_blocks).

---
 rtl/io_cfg_pkg.sv | 37 +++
 rtl/prog_tick_div.sv | 36 +++
 rtl/prog_chain_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/io_cfg_pkg.sv
// Shared definitions for serial program-chain controllers.
// Contents:
//   ST_*         FSM state encodings (legacy-compatible 3-bit constants)
//   ceil_div     integer ceiling division
//   clog2_min1   ceil(log2(v)) clamped to at least 1, for counter widths
//   num_words    number of words needed to cover a chain
//   last_word_w  number of valid bits in the final word of a chain
package io_cfg_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int num_words(input int chain_len, input int word_w);
    return ceil_div(chain_len, word_w);
  endfunction

  function automatic int last_word_w(input int chain_len, input int word_w);
    return chain_len - (num_words(chain_len, word_w) - 1) * word_w;
  endfunction

endpackage

// File: rtl/prog_tick_div.sv
// Half-period divider for the generated program clock.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_run        high while the controller is in a shift phase
//   o_phase_end  high on the last clk cycle of each CLK_DIV-cycle phase
// The counter is held at zero whenever i_run is low, so every bit begins
// with a full-length low phase after a FETCH.
module prog_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_phase_end
);
  import io_cfg_pkg::*;

  localparam int            CW       = clog2_min1(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_phase_end = i_run && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_chain_loader.sv
// Configuration controller for the serial program chain of an io_bank.
// Accepts CHAIN_LEN config bits as WORD_W-bit words (LSB first) and shifts
// them out on prog_in/prog_clk/prog_en, capturing prog_out on each bit so
// the previous chain contents come back as readback words.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   start                begin a load (honoured only in IDLE)
//   cfg_data/valid/ready config word stream (ready high in FETCH)
//   rb_data/rb_valid     readback word + 1-cycle strobe, no backpressure
//   busy, done           activity flag, 1-cycle completion strobe
//   prog_in/clk/en       serial chain drive
//   prog_out             serial data returned from the chain end
// All outputs are registers loaded from the next-state decode.
module prog_chain_loader #(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out
);
  import io_cfg_pkg::*;

  localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int LAST_W    = last_word_w(CHAIN_LEN, WORD_W);
  localparam int BW        = clog2_min1(WORD_W);
  localparam int WCW       = clog2_min1(NUM_WORDS);

  localparam logic [BW-1:0]  BIT_LAST_FULL = BW'(WORD_W - 1);
  localparam logic [BW-1:0]  BIT_LAST_TAIL = BW'(LAST_W - 1);
  localparam logic [WCW-1:0] WORD_LAST     = WCW'(NUM_WORDS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [WCW-1:0]    r_word_cnt;
  logic [WORD_W-1:0] r_tx;
  logic [WORD_W-1:0] r_rb_cap;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_cfg_ready, r_rb_valid, r_busy, r_done;
  logic              r_prog_in, r_prog_clk, r_prog_en;

  logic              w_run, w_phase_end, w_last_word, w_word_end, w_take;
  logic              w_lo_end, w_hi_end;
  logic [BW-1:0]     w_bit_nxt;

  assign w_run       = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);
  assign w_last_word = (r_word_cnt == WORD_LAST);
  // The final word may be shorter than WORD_W; its unused bits are never shifted.
  assign w_word_end  = (r_bit_cnt == (w_last_word ? BIT_LAST_TAIL : BIT_LAST_FULL));
  assign w_take      = r_cfg_ready && cfg_valid;
  assign w_lo_end    = (r_state == ST_SHIFT_LO) && w_phase_end;
  assign w_hi_end    = (r_state == ST_SHIFT_HI) && w_phase_end;
  assign w_bit_nxt   = r_bit_cnt + BW'(1);

  prog_tick_div #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (w_run),
    .o_phase_end (w_phase_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_state_nxt = ST_FETCH;
      ST_FETCH:    if (w_take) w_state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_phase_end) w_state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          if (!w_word_end)       w_state_nxt = ST_SHIFT_LO;
          else if (!w_last_word) w_state_nxt = ST_FETCH;
          else                   w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_rb_data   <= '0;
      r_cfg_ready <= 1'b0;
      r_rb_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_prog_in   <= 1'b0;
      r_prog_clk  <= 1'b0;
      r_prog_en   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == ST_FETCH);
      r_prog_clk  <= (w_state_nxt == ST_SHIFT_HI);
      r_prog_en   <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_SHIFT_LO) ||
                     (w_state_nxt == ST_SHIFT_HI);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_rb_valid  <= 1'b0;

      if (w_take) begin
        r_bit_cnt <= '0;
        r_prog_in <= cfg_data[0];
      end

      if (w_hi_end) begin
        if (w_word_end) begin
          r_rb_data  <= r_rb_cap;
          r_rb_valid <= 1'b1;
          r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCW'(1);
          if (w_last_word) r_prog_in <= 1'b0;
        end else begin
          r_bit_cnt <= w_bit_nxt;
          r_prog_in <= r_tx[w_bit_nxt];
        end
      end
    end
  end

  // Word data registers: cleared per word by the handshake, not by reset
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_tx     <= cfg_data;
      r_rb_cap <= '0;
    end else if (w_lo_end) begin
      // Sample just before the rising prog_clk edge, while the chain end is stable.
      r_rb_cap[r_bit_cnt] <= prog_out;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign rb_data   = r_rb_data;
  assign rb_valid  = r_rb_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign prog_in   = r_prog_in;
  assign prog_clk  = r_prog_clk;
  assign prog_en   = r_prog_en;

endmodule
